// File: rtl/sync_w2r_status_if.sv
`timescale 1ps/1ps
`default_nettype none
// ============================================================================
// sync_w2r_status_if : write-pointer sync / read-status bundle    Rev 1.0
// ============================================================================
interface sync_w2r_status_if #(
  parameter int ADDRSIZE = 4
);
  logic [ADDRSIZE:0] wptr_gray;
  logic [ADDRSIZE:0] rbin_next;
  logic [ADDRSIZE:0] ae_thresh;
  logic [ADDRSIZE:0] rq_wptr_gray;
  logic [ADDRSIZE:0] rq_wptr_bin;
  logic [ADDRSIZE:0] rd_count;
  logic              rempty;
  logic              ralmost_empty;
  logic              wptr_upd;
  logic              occ_err;

  modport master (
    output wptr_gray, rbin_next, ae_thresh,
    input  rq_wptr_gray, rq_wptr_bin, rd_count, rempty, ralmost_empty,
           wptr_upd, occ_err
  );

  modport slave (
    input  wptr_gray, rbin_next, ae_thresh,
    output rq_wptr_gray, rq_wptr_bin, rd_count, rempty, ralmost_empty,
           wptr_upd, occ_err
  );
endinterface
`default_nettype wire

// File: rtl/sync_w2r_status.sv
`timescale 1ps/1ps
`default_nettype none
// ============================================================================
// sync_w2r_status : Gray write-pointer synchronizer and read-side status
//                   (occupancy, empty, almost-empty, update pulse, error)
// Rev 1.0
// ============================================================================
module sync_w2r_status #(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             rclk,
  input  logic             rrst_n,
  sync_w2r_status_if.slave bus
);

  localparam logic [ADDRSIZE:0] c_DEPTH = (ADDRSIZE+1)'(1 << ADDRSIZE);

  logic [ADDRSIZE:0] r_sync [SYNC_STAGES];
  logic [ADDRSIZE:0] r_shadow;
  logic [ADDRSIZE:0] r_rd_count;
  logic              r_rempty;
  logic              r_ralmost_empty;
  logic              r_wptr_upd;
  logic              r_occ_err;

  logic [ADDRSIZE:0] w_rq_gray;
  logic [ADDRSIZE:0] w_rq_bin;
  logic [ADDRSIZE:0] w_cnt_next;

  // Plain flop chain: stage 0 samples the foreign-domain pointer directly.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= bus.wptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_rq_gray = r_sync[SYNC_STAGES-1];

  // Binary bit i is the XOR of all Gray bits at and above i.
  genvar gi;
  for (gi = 0; gi <= ADDRSIZE; gi++) begin : g_g2b
    assign w_rq_bin[gi] = ^w_rq_gray[ADDRSIZE:gi];
  end

  assign w_cnt_next = w_rq_bin - bus.rbin_next;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_shadow        <= '0;
      r_rd_count      <= '0;
      r_rempty        <= 1'b1;
      r_ralmost_empty <= 1'b1;
      r_wptr_upd      <= 1'b0;
      r_occ_err       <= 1'b0;
    end else begin
      r_shadow        <= w_rq_gray;
      r_wptr_upd      <= (w_rq_gray != r_shadow);
      r_rd_count      <= w_cnt_next;
      r_rempty        <= (w_cnt_next == '0);
      r_ralmost_empty <= (w_cnt_next <= bus.ae_thresh);
      // Exactly DEPTH is a legal full FIFO; only beyond that is inconsistent.
      if (w_cnt_next > c_DEPTH) r_occ_err <= 1'b1;
    end
  end

  assign bus.rq_wptr_gray  = w_rq_gray;
  assign bus.rq_wptr_bin   = w_rq_bin;
  assign bus.rd_count      = r_rd_count;
  assign bus.rempty        = r_rempty;
  assign bus.ralmost_empty = r_ralmost_empty;
  assign bus.wptr_upd      = r_wptr_upd;
  assign bus.occ_err       = r_occ_err;

endmodule
`default_nettype wire

// File: tb/tb_sync_w2r_status.sv
`timescale 1ps/1ps
`default_nettype none
// ============================================================================
// tb_sync_w2r_status : directed + randomized bench for sync_w2r_status
// Rev 1.0
// ============================================================================
module tb_sync_w2r_status;

  localparam int AW = 4;

  logic          rclk;
  logic          rrst_n;
  logic [AW:0]   wptr_gray;
  logic [AW:0]   rbin_next;
  logic [AW:0]   ae_thresh;
  logic          rnd_on;

  int n_chk  = 0;
  int n_fail = 0;

  sync_w2r_status_if #(.ADDRSIZE(AW)) bus2 ();
  sync_w2r_status_if #(.ADDRSIZE(AW)) bus3 ();
  sync_w2r_status_if #(.ADDRSIZE(AW)) bus4 ();

  assign bus2.wptr_gray = wptr_gray;
  assign bus2.rbin_next = rbin_next;
  assign bus2.ae_thresh = ae_thresh;
  assign bus3.wptr_gray = wptr_gray;
  assign bus3.rbin_next = rbin_next;
  assign bus3.ae_thresh = ae_thresh;
  assign bus4.wptr_gray = wptr_gray;
  assign bus4.rbin_next = rbin_next;
  assign bus4.ae_thresh = ae_thresh;

  sync_w2r_status #(.ADDRSIZE(AW), .SYNC_STAGES(2)) u_dut2 (
    .rclk(rclk), .rrst_n(rrst_n), .bus(bus2.slave));
  sync_w2r_status #(.ADDRSIZE(AW), .SYNC_STAGES(3)) u_dut3 (
    .rclk(rclk), .rrst_n(rrst_n), .bus(bus3.slave));
  sync_w2r_status #(.ADDRSIZE(AW), .SYNC_STAGES(4)) u_dut4 (
    .rclk(rclk), .rrst_n(rrst_n), .bus(bus4.slave));

  initial begin
    rclk = 1'b0;
    forever #5000 rclk = ~rclk;
  end

  function automatic int g2b(input int g);
    int b = 0;
    for (int k = 0; k < 6; k++) b = b ^ (g >> k);
    return b;
  endfunction

  function automatic int b2g(input int b);
    return b ^ (b >> 1);
  endfunction

  // Reference model for the 2-stage instance: pointer delayed by 2 edges,
  // status derived from the delayed pointer and the read pointer.
  int m_q[$];
  int m_cnt;
  int m_empty;
  int m_ae;
  int m_err;

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      m_q = {};
      for (int i = 0; i < 2; i++) m_q.push_back(0);
      m_cnt = 0; m_empty = 1; m_ae = 1; m_err = 0;
    end else begin
      int c;
      c = (g2b(m_q[0]) - int'(rbin_next) + 32) % 32;
      m_cnt   = c;
      m_empty = (c == 0) ? 1 : 0;
      m_ae    = (c <= int'(ae_thresh)) ? 1 : 0;
      if (c > 16) m_err = 1;
      m_q.push_back(int'(wptr_gray));
      void'(m_q.pop_front());
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rq"},    32'(bus2.rq_wptr_gray),  0);
    chk({tag, "_cnt"},   32'(bus2.rd_count),      0);
    chk({tag, "_empty"}, 32'(bus2.rempty),        1);
    chk({tag, "_ae"},    32'(bus2.ralmost_empty), 1);
    chk({tag, "_upd"},   32'(bus2.wptr_upd),      0);
    chk({tag, "_err"},   32'(bus2.occ_err),       0);
  endtask

  initial begin
    int u2, u3, u4;
    rrst_n = 1'b0; wptr_gray = '0; rbin_next = '0; ae_thresh = '0; rnd_on = 1'b0;
    repeat (3) step();
    chk_reset("rst");
    rrst_n = 1'b1;
    repeat (4) step();

    // Latency for 2/3/4 stages and single update pulse each
    wptr_gray = 5'd1;
    u2 = 0; u3 = 0; u4 = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      u2 += int'(bus2.wptr_upd);
      u3 += int'(bus3.wptr_upd);
      u4 += int'(bus4.wptr_upd);
      if (k <= 4) begin
        chk("lat2", 32'(bus2.rq_wptr_gray), (k >= 2) ? 1 : 0);
        chk("lat3", 32'(bus3.rq_wptr_gray), (k >= 3) ? 1 : 0);
        chk("lat4", 32'(bus4.rq_wptr_gray), (k >= 4) ? 1 : 0);
      end
    end
    chk("upd2", u2, 1);
    chk("upd3", u3, 1);
    chk("upd4", u4, 1);

    // Empty and count
    wptr_gray = 5'(b2g(3));
    repeat (4) step();
    rbin_next = 5'd3;
    repeat (2) step();
    chk("empty_eq", 32'(bus2.rempty), 1);
    chk("cnt_eq",   32'(bus2.rd_count), 0);
    wptr_gray = 5'(b2g(7));
    repeat (4) step();
    chk("cnt4",   32'(bus2.rd_count), 4);
    chk("empty4", 32'(bus2.rempty), 0);
    chk("ae0",    32'(bus2.ralmost_empty), 0);
    chk("bin7",   32'(bus2.rq_wptr_bin), 7);
    ae_thresh = 5'd4;
    step();
    chk("ae4", 32'(bus2.ralmost_empty), 1);
    ae_thresh = 5'd3;
    step();
    chk("ae3", 32'(bus2.ralmost_empty), 0);
    ae_thresh = 5'd0;

    // Reset in the middle of operation
    wptr_gray = 5'(b2g(12));
    repeat (4) step();
    chk("cnt9", 32'(bus2.rd_count), 9);
    #2000;
    rrst_n = 1'b0;
    rbin_next = '0;
    #1;
    chk_reset("midrst");
    @(negedge rclk);
    rrst_n = 1'b1;
    step();
    chk("rec1_rq", 32'(bus2.rq_wptr_gray), 0);
    step();
    chk("rec2_rq", 32'(bus2.rq_wptr_gray), b2g(12));
    step();
    chk("rec3_cnt", 32'(bus2.rd_count), 12);

    // Wrap: MSB toggle with equal low bits is full, not error
    rbin_next = 5'd7;
    wptr_gray = 5'(b2g(15));
    repeat (4) step();
    rbin_next = 5'd15;
    repeat (2) step();
    wptr_gray = 5'(b2g(31));
    repeat (4) step();
    chk("wrap_cnt",   32'(bus2.rd_count), 16);
    chk("wrap_empty", 32'(bus2.rempty), 0);
    chk("wrap_err",   32'(bus2.occ_err), 0);
    chk("wrap_bin",   32'(bus2.rq_wptr_bin), 31);

    // Occupancy error, sticky
    rrst_n = 1'b0; wptr_gray = '0; rbin_next = '0;
    repeat (2) step();
    rrst_n = 1'b1;
    repeat (4) step();
    chk("err_pre", 32'(bus2.occ_err), 0);
    wptr_gray = 5'(b2g(17));
    repeat (2) step();
    chk("err_sync_rq", 32'(bus2.rq_wptr_gray), b2g(17));
    chk("err_not_yet", 32'(bus2.occ_err), 0);
    step();
    chk("err_set", 32'(bus2.occ_err), 1);
    chk("err_cnt", 32'(bus2.rd_count), 17);
    wptr_gray = '0;
    repeat (5) step();
    chk("err_sticky", 32'(bus2.occ_err), 1);
    chk("err_cnt0",   32'(bus2.rd_count), 0);
    chk("err_empty",  32'(bus2.rempty), 1);

    // Randomized async writer against the reference model
    rrst_n = 1'b0; wptr_gray = '0; rbin_next = '0;
    ae_thresh = 5'($urandom_range(0, 16));
    repeat (2) step();
    rrst_n = 1'b1;
    rnd_on = 1'b1;
    fork
      begin : writer
        int wbin;
        longint ph;
        wbin = 0;
        while (rnd_on) begin
          #($urandom_range(3000, 30000));
          ph = $time % 10000;
          if (ph >= 4500 && ph <= 5500) #1000;
          if (((wbin - int'(rbin_next)) & 31) < 16) begin
            wbin = (wbin + 1) & 31;
            wptr_gray = 5'(b2g(wbin));
          end
        end
      end
      begin : reader
        for (int n = 0; n < 3000; n++) begin
          step();
          chk("rnd_rq",    32'(bus2.rq_wptr_gray),  m_q[0]);
          chk("rnd_bin",   32'(bus2.rq_wptr_bin),   g2b(m_q[0]));
          chk("rnd_cnt",   32'(bus2.rd_count),      m_cnt);
          chk("rnd_empty", 32'(bus2.rempty),        m_empty);
          chk("rnd_ae",    32'(bus2.ralmost_empty), m_ae);
          chk("rnd_err",   32'(bus2.occ_err),       0);
          chk("rnd_le16",  32'(bus2.rd_count <= 5'd16), 1);
          if (n % 700 == 699) ae_thresh = 5'($urandom_range(0, 16));
          if ($urandom_range(0, 1) == 1 && int'(rbin_next) != g2b(m_q[0]))
            rbin_next = rbin_next + 5'd1;
        end
        rnd_on = 1'b0;
      end
    join
    chk("model_err", m_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_w2r_status.md
SYNC_W2R_STATUS -- requirements
Module: sync_w2r_status

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4, meaning FIFO address width; depth DEPTH = 2^ADDRSIZE.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flop count; legal range 2..4.
REQ-003 SHALL have port rclk  input  1  read-domain clock, rising-edge active.
REQ-004 SHALL have port rrst_n  input  1  asynchronous, active-low reset for all read-domain state.
REQ-005 SHALL have port wptr_gray  input  ADDRSIZE+1  write pointer, Gray-coded, from the write clock domain.
REQ-006 SHALL have port rbin_next  input  ADDRSIZE+1  next-cycle binary read pointer from read control.
REQ-007 SHALL have port ae_thresh  input  ADDRSIZE+1  almost-empty threshold, quasi-static.
REQ-008 SHALL have port rq_wptr_gray  output  ADDRSIZE+1  synchronized Gray write pointer, last chain stage.
REQ-009 SHALL have port rq_wptr_bin  output  ADDRSIZE+1  binary equivalent of rq_wptr_gray, combinational.
REQ-010 SHALL have port rd_count  output  ADDRSIZE+1  registered read-side occupancy.
REQ-011 SHALL have port rempty  output  1  registered empty flag.
REQ-012 SHALL have port ralmost_empty  output  1  registered almost-empty flag.
REQ-013 SHALL have port wptr_upd  output  1  one-cycle pulse: synchronized pointer changed.
REQ-014 SHALL have port occ_err  output  1  sticky occupancy-overflow error.

Function
REQ-015 SHALL pass wptr_gray through SYNC_STAGES cascaded flops on rclk; a stable input appears on rq_wptr_gray exactly SYNC_STAGES rising edges after first sampling.
REQ-016 SHALL place no logic between synchronizer stages; stage 1 samples wptr_gray directly.
REQ-017 SHALL compute rq_wptr_bin by Gray-to-binary: bit ADDRSIZE = gray MSB; bit i = bin[i+1] XOR gray[i].
REQ-018 SHALL compute cnt_next = (rq_wptr_bin - rbin_next) modulo 2^(ADDRSIZE+1), unsigned, ADDRSIZE+1 bits.
REQ-019 SHALL register rd_count <= cnt_next every rclk edge.
REQ-020 SHALL register rempty <= (rq_wptr_gray == Gray(rbin_next)), equivalently cnt_next == 0.
REQ-021 SHALL register ralmost_empty <= (cnt_next <= ae_thresh); ae_thresh = 0 makes it equal rempty.
REQ-022 SHALL hold a shadow of the previous rq_wptr_gray and pulse wptr_upd high for one cycle when the values differ.
REQ-023 SHALL set occ_err when cnt_next > DEPTH and hold it high until reset; rd_count, rempty and ralmost_empty still update normally.
REQ-024 SHALL handle pointer wrap: MSB toggle with equal lower bits gives cnt_next = DEPTH (full), not error.
REQ-025 SHALL treat multi-increment jumps between rclk samples, such as a fast write clock, as legal; only REQ-023 flags errors.

Reset
REQ-026 SHALL, on rrst_n low, asynchronously clear all synchronizer stages and the shadow register to 0.
REQ-027 SHALL, on rrst_n low, drive rd_count = 0, rempty = 1, ralmost_empty = 1, wptr_upd = 0 and occ_err = 0.
REQ-028 SHALL release reset synchronously to rclk, with deassertion synchronized outside this block; the first edge after release performs a normal update.
REQ-029 SHALL abandon in-flight synchronizer contents on reset mid-operation; after release, the output reflects wptr_gray only after SYNC_STAGES edges.

Verification
REQ-030 SHALL pass latency: ADDRSIZE=4, SYNC_STAGES=2/3/4, step wptr_gray 0->1 -> rq_wptr_gray=1 after exactly 2/3/4 edges; wptr_upd pulses once.
REQ-031 SHALL pass empty/count: rbin_next=3, wptr_gray=Gray(3) -> rempty=1, rd_count=0; then wptr_gray=Gray(7) -> rd_count=4, rempty=0; ae_thresh=4 -> ralmost_empty=1.
REQ-032 SHALL pass wrap: rbin_next=5'b01111, wptr_gray=Gray(5'b11111) -> rd_count=16, rempty=0, occ_err=0.
REQ-033 SHALL pass error: rbin_next=0, wptr_gray=Gray(17) -> occ_err=1 one edge after sync, and it remains 1 after wptr_gray returns to Gray(0).
REQ-034 SHALL pass reset mid-operation: rd_count=9 with rrst_n pulsed low between edges -> outputs immediately reset per REQ-027; recovery follows REQ-029.
REQ-035 SHALL pass random: an async write clock at 0.3x-3x rclk driving legal Gray pointers -> rd_count never exceeds 16 and occ_err stays 0.
